// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule controller.
// Optional round-key store is enabled with AES_KEY_STORE_EN.
package aes_pkg;

  typedef logic [127:0] key_128;
  typedef logic [31:0]  aes_word;

  // Index 0 and 11..15 are unused and read as 0.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'h00
  };

  typedef enum logic [1:0] {
    KSC_IDLE   = 2'd0,
    KSC_FETCH  = 2'd1,
    KSC_EXPAND = 2'd2,
    KSC_WRAP   = 2'd3
  } ksc_state_e;

endpackage

// File: rtl/aes_rk_store.sv
// 11 x 128-bit round-key store, one write port, one registered read port.
// Used only when AES_KEY_STORE_EN is defined.
module aes_rk_store
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  key_128     wdata,
  input  logic [3:0] raddr,
  output key_128     rdata
);

  key_128 mem [0:10];

  always_ff @(posedge clk) begin
    if (we && waddr < 4'd11) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata <= '0;
    end else if (raddr < 4'd11) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer driving the key-generation round stage.
// Define AES_KEY_STORE_EN to add the 11-entry round-key store and read port.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_RND = 10
)
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid_i,
  output logic       key_ready_o,
  input  key_128     key_i,
  input  logic       flush_i,
  output logic       kg_en_o,
  output logic       kg_gen_key_o,
  output logic       kg_next_rnd_o,
  output logic [7:0] kg_rcon_o,
  output key_128     kg_key_o,
  input  key_128     kg_key_i,
  output logic       rk_valid_o,
  output logic [3:0] rk_idx_o,
  output key_128     rk_o,
  output logic       done_o
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0] rk_rd_addr_i,
  output key_128     rk_rd_data_o
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NUM_RND);

  ksc_state_e state, state_nx;
  logic [3:0] rnd;
  logic       hs;
  logic       smp;
  logic       last;
  logic       wrap;

  assign key_ready_o = (state == KSC_IDLE) & ~flush_i;
  assign hs          = key_valid_i & key_ready_o;
  assign last        = rnd == LAST_RND;
  assign wrap        = state == KSC_WRAP;

  always_comb begin
    state_nx      = state;
    kg_en_o       = 1'b0;
    kg_gen_key_o  = 1'b0;
    kg_next_rnd_o = 1'b0;
    kg_rcon_o     = '0;
    smp           = 1'b0;
    unique case (state)
      KSC_IDLE: begin
        if (hs) state_nx = KSC_FETCH;
      end
      KSC_FETCH: begin
        kg_en_o       = 1'b1;
        kg_next_rnd_o = rnd != 4'd1;
        smp           = rnd > 4'd1;
        state_nx      = KSC_EXPAND;
      end
      KSC_EXPAND: begin
        kg_en_o      = 1'b1;
        kg_gen_key_o = 1'b1;
        kg_rcon_o    = RCON[rnd];
        state_nx     = last ? KSC_WRAP : KSC_FETCH;
      end
      KSC_WRAP: begin
        smp      = 1'b1;
        state_nx = KSC_IDLE;
      end
      default: state_nx = KSC_IDLE;
    endcase
    if (flush_i) state_nx = KSC_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= KSC_IDLE;
      rnd        <= '0;
      kg_key_o   <= '0;
      rk_valid_o <= 1'b0;
      rk_idx_o   <= '0;
      rk_o       <= '0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nx;
      rk_valid_o <= 1'b0;
      done_o     <= 1'b0;
      if (flush_i) begin
        rnd <= '0;
      end else if (hs) begin
        rnd <= 4'd1;
      end else if (state == KSC_EXPAND && !last) begin
        rnd <= rnd + 4'd1;
      end
      // Round key 0 is the cipher key itself, streamed straight from the handshake.
      if (hs) begin
        kg_key_o   <= key_i;
        rk_valid_o <= 1'b1;
        rk_idx_o   <= '0;
        rk_o       <= key_i;
      end
      if (smp && !flush_i) begin
        rk_valid_o <= 1'b1;
        rk_idx_o   <= wrap ? rnd : rnd - 4'd1;
        rk_o       <= kg_key_i;
        done_o     <= wrap;
      end
    end
  end

`ifdef AES_KEY_STORE_EN
  aes_rk_store u_store (
    .clk   (clk),
    .nrst  (nrst),
    .we    (rk_valid_o),
    .waddr (rk_idx_o),
    .wdata (rk_o),
    .raddr (rk_rd_addr_i),
    .rdata (rk_rd_data_o)
  );
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl with a behavioural key-generation stage.
// Store checks are compiled in when AES_KEY_STORE_EN is defined.
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  localparam key_128 FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam key_128 FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam key_128 FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic key_valid_i = 1'b0;
  logic key_ready_o;
  key_128 key_i = '0;
  logic flush_i = 1'b0;
  logic kg_en_o, kg_gen_key_o, kg_next_rnd_o;
  logic [7:0] kg_rcon_o;
  key_128 kg_key_o, kg_key_i;
  logic rk_valid_o;
  logic [3:0] rk_idx_o;
  key_128 rk_o;
  logic done_o;
`ifdef AES_KEY_STORE_EN
  logic [3:0] rk_rd_addr_i = '0;
  key_128 rk_rd_data_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sbox_t [0:255];
  key_128 ref_rk [0:2][0:10];
  key_128 kg_cur, kg_out;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk(clk),
    .nrst(nrst),
    .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o),
    .key_i(key_i),
    .flush_i(flush_i),
    .kg_en_o(kg_en_o),
    .kg_gen_key_o(kg_gen_key_o),
    .kg_next_rnd_o(kg_next_rnd_o),
    .kg_rcon_o(kg_rcon_o),
    .kg_key_o(kg_key_o),
    .kg_key_i(kg_key_i),
    .rk_valid_o(rk_valid_o),
    .rk_idx_o(rk_idx_o),
    .rk_o(rk_o),
    .done_o(done_o)
`ifdef AES_KEY_STORE_EN
    ,
    .rk_rd_addr_i(rk_rd_addr_i),
    .rk_rd_data_o(rk_rd_data_o)
`endif
  );

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_word sub_word(input aes_word w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [7:0] ref_rcon(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return rc;
  endfunction

  // Key-generation round stage: FETCH loads, EXPAND computes one round.
  function automatic key_128 kg_round(input key_128 k, input logic [7:0] rc);
    aes_word t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      kg_cur <= '0;
      kg_out <= '0;
    end else if (kg_en_o) begin
      if (kg_gen_key_o) kg_out <= kg_round(kg_cur, kg_rcon_o);
      else kg_cur <= kg_next_rnd_o ? kg_out : kg_key_o;
    end
  end
  assign kg_key_i = kg_out;

  // Reference: FIPS-197 word recurrence over w[0..43].
  task automatic ref_fill(input int s, input key_128 k);
    aes_word w [0:43];
    aes_word t;
    logic [7:0] rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      ref_rk[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    key_valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({kg_en_o, kg_gen_key_o, kg_next_rnd_o, rk_valid_o, done_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 00000",
               {kg_en_o, kg_gen_key_o, kg_next_rnd_o, rk_valid_o, done_o});
    end
    vectors++;
    if (kg_rcon_o !== 8'h0 || rk_idx_o !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_rcon_idx got %h/%h want 00/0", kg_rcon_o, rk_idx_o);
    end
    vectors++;
    if (kg_key_o !== '0 || rk_o !== '0) begin
      miscompares++;
      $display("FAIL reset_keys got %h/%h want 0", kg_key_o, rk_o);
    end
    @(negedge clk);
    nrst = 1'b1;
    #1;
    vectors++;
    if (key_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 1", key_ready_o);
    end
  endtask

  task automatic test_fips();
    logic [7:0] rq [$];
    int fetch_n;
    fetch_n = 0;
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      key_valid_i = (c == 0);
      key_i = FIPS_KEY;
      #1;
      if (c == 4) begin
        vectors++;
        if (rk_valid_o !== 1'b1 || rk_idx_o !== 4'd1 || rk_o !== FIPS_RK1) begin
          miscompares++;
          $display("FAIL fips_rk1 got v=%b i=%0d %h want v=1 i=1 %h",
                   rk_valid_o, rk_idx_o, rk_o, FIPS_RK1);
        end
      end
      if (c == 22) begin
        vectors++;
        if (rk_valid_o !== 1'b1 || rk_idx_o !== 4'd10 || rk_o !== FIPS_RK10) begin
          miscompares++;
          $display("FAIL fips_rk10 got v=%b i=%0d %h want v=1 i=10 %h",
                   rk_valid_o, rk_idx_o, rk_o, FIPS_RK10);
        end
        vectors++;
        if (key_ready_o !== 1'b1) begin
          miscompares++;
          $display("FAIL fips_ready22 got %b want 1", key_ready_o);
        end
      end
      vectors++;
      if (done_o !== (c == 22)) begin
        miscompares++;
        $display("FAIL fips_done c=%0d got %b want %b", c, done_o, c == 22);
      end
      if (kg_gen_key_o === 1'b1) begin
        rq.push_back(kg_rcon_o);
      end else begin
        vectors++;
        if (kg_rcon_o !== 8'h00) begin
          miscompares++;
          $display("FAIL fips_rcon_idle c=%0d got %h want 00", c, kg_rcon_o);
        end
      end
      if (kg_en_o === 1'b1 && kg_gen_key_o === 1'b0) begin
        fetch_n++;
        vectors++;
        if (kg_next_rnd_o !== (fetch_n != 1)) begin
          miscompares++;
          $display("FAIL fips_next_rnd fetch=%0d got %b want %b",
                   fetch_n, kg_next_rnd_o, fetch_n != 1);
        end
      end
    end
    vectors++;
    if (rq.size() != 10) begin
      miscompares++;
      $display("FAIL fips_rcon_count got %0d want 10", rq.size());
    end
    for (int i = 0; i < rq.size() && i < 10; i++) begin
      vectors++;
      if (rq[i] !== ref_rcon(i + 1)) begin
        miscompares++;
        $display("FAIL fips_rcon r=%0d got %h want %h", i + 1, rq[i], ref_rcon(i + 1));
      end
    end
  endtask

`ifdef AES_KEY_STORE_EN
  task automatic test_store();
    logic [3:0] addrs [0:3];
    key_128 exp_d [0:3];
    addrs[0] = 4'd0;  exp_d[0] = FIPS_KEY;
    addrs[1] = 4'd1;  exp_d[1] = FIPS_RK1;
    addrs[2] = 4'd10; exp_d[2] = FIPS_RK10;
    addrs[3] = 4'd12; exp_d[3] = '0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) rk_rd_addr_i = addrs[i];
      #1;
      if (i > 0) begin
        vectors++;
        if (rk_rd_data_o !== exp_d[i-1]) begin
          miscompares++;
          $display("FAIL store_rd a=%0d got %h want %h", addrs[i-1], rk_rd_data_o, exp_d[i-1]);
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    key_128 keys [0:2];
    int seen [0:10];
    logic ev, ee, eg, en, er, ed;
    logic [3:0] ei;
    logic [7:0] ec;
    int k, c;
    for (int i = 0; i < 3; i++) begin
      keys[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_fill(i, keys[i]);
    end
    for (int i = 0; i <= 10; i++) seen[i] = 0;
    for (int t = 0; t <= 66; t++) begin
      @(negedge clk);
      key_valid_i = (t < 66);
      if (t < 66) key_i = keys[t / 22];
      #1;
      k = t / 22;
      c = t % 22;
      if (c == 0 && k > 0) begin
        k = k - 1;
        c = 22;
      end
      ev = (c == 1) || (c >= 4 && c % 2 == 0);
      ei = (c == 1) ? 4'd0 : 4'(c / 2 - 1);
      ed = (c == 22);
      ee = (c >= 1 && c <= 20);
      eg = ee && (c % 2 == 0);
      en = (c >= 3 && c <= 19 && c % 2 == 1);
      ec = eg ? ref_rcon(c / 2) : 8'h00;
      er = (c == 0 || c == 22);
      vectors++;
      if ({rk_valid_o, done_o, key_ready_o} !== {ev, ed, er}) begin
        miscompares++;
        $display("FAIL b2b_strobe t=%0d got v/d/r=%b want %b",
                 t, {rk_valid_o, done_o, key_ready_o}, {ev, ed, er});
      end
      vectors++;
      if ({kg_en_o, kg_gen_key_o, kg_next_rnd_o, kg_rcon_o} !== {ee, eg, en, ec}) begin
        miscompares++;
        $display("FAIL b2b_kg t=%0d got en/gen/nx/rc=%b%b%b/%h want %b%b%b/%h",
                 t, kg_en_o, kg_gen_key_o, kg_next_rnd_o, kg_rcon_o, ee, eg, en, ec);
      end
      if (ev) begin
        vectors++;
        if (rk_idx_o !== ei || rk_o !== ref_rk[k][ei]) begin
          miscompares++;
          $display("FAIL b2b_rk t=%0d got i=%0d %h want i=%0d %h",
                   t, rk_idx_o, rk_o, ei, ref_rk[k][ei]);
        end
      end
      if (rk_valid_o === 1'b1 && k == 0 && rk_idx_o <= 4'd10) seen[rk_idx_o]++;
      if (c >= 1) begin
        vectors++;
        if (kg_key_o !== keys[k]) begin
          miscompares++;
          $display("FAIL b2b_kg_key t=%0d got %h want %h", t, kg_key_o, keys[k]);
        end
      end
    end
    key_valid_i = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      vectors++;
      if (seen[i] != 1) begin
        miscompares++;
        $display("FAIL b2b_seen idx=%0d got %0d want 1", i, seen[i]);
      end
    end
  endtask

  task automatic test_flush();
    key_128 key;
    logic ev;
    logic [3:0] ei;
    key = {$urandom, $urandom, $urandom, $urandom};
    ref_fill(0, key);
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      key_valid_i = (c == 0);
      key_i = key;
      flush_i = (c == 9);
      #1;
      ev = (c < 9) && ((c == 1) || (c >= 4 && c % 2 == 0));
      ei = (c == 1) ? 4'd0 : 4'(c / 2 - 1);
      vectors++;
      if (rk_valid_o !== ev || done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_strobe c=%0d got v/d=%b%b want %b0", c, rk_valid_o, done_o, ev);
      end
      if (ev) begin
        vectors++;
        if (rk_o !== ref_rk[0][ei]) begin
          miscompares++;
          $display("FAIL flush_rk c=%0d got %h want %h", c, rk_o, ref_rk[0][ei]);
        end
      end
      if (c >= 10) begin
        vectors++;
        if (key_ready_o !== 1'b1 || kg_en_o !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_idle c=%0d got r/en=%b%b want 10", c, key_ready_o, kg_en_o);
        end
      end
    end
    flush_i = 1'b0;
    @(negedge clk);
    key_valid_i = 1'b1;
    flush_i = 1'b1;
    key_i = {$urandom, $urandom, $urandom, $urandom};
    #1;
    vectors++;
    if (key_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_hs_ready got %b want 0", key_ready_o);
    end
    @(negedge clk);
    key_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    vectors++;
    if (kg_en_o !== 1'b0 || rk_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_hs_taken got en/v=%b%b want 00", kg_en_o, rk_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic ev;
    key_i = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      key_valid_i = (c == 0);
      if (c == 13) nrst = 1'b0;
      #1;
    end
    vectors++;
    if ({kg_en_o, kg_gen_key_o, kg_next_rnd_o, rk_valid_o, done_o} !== 5'b0
        || kg_rcon_o !== 8'h0 || rk_idx_o !== 4'h0) begin
      miscompares++;
      $display("FAIL rstmid_ctl got %b/%h/%h want 0",
               {kg_en_o, kg_gen_key_o, kg_next_rnd_o, rk_valid_o, done_o},
               kg_rcon_o, rk_idx_o);
    end
    vectors++;
    if (kg_key_o !== '0 || rk_o !== '0) begin
      miscompares++;
      $display("FAIL rstmid_keys got %h/%h want 0", kg_key_o, rk_o);
    end
    @(negedge clk);
    nrst = 1'b1;
    #1;
    vectors++;
    if (key_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_ready got %b want 1", key_ready_o);
    end
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      key_valid_i = (c == 0);
      key_i = FIPS_KEY;
      #1;
      ev = (c == 1) || (c >= 4 && c % 2 == 0);
      vectors++;
      if (rk_valid_o !== ev || done_o !== (c == 22)) begin
        miscompares++;
        $display("FAIL rstmid_strobe c=%0d got v/d=%b%b want %b%b",
                 c, rk_valid_o, done_o, ev, c == 22);
      end
      if (c == 4 || c == 22) begin
        vectors++;
        if (rk_o !== ((c == 4) ? FIPS_RK1 : FIPS_RK10)) begin
          miscompares++;
          $display("FAIL rstmid_rk c=%0d got %h want %h",
                   c, rk_o, (c == 4) ? FIPS_RK1 : FIPS_RK10);
        end
      end
    end
    key_valid_i = 1'b0;
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(x));
      sbox_t[x] = affine(inv);
    end
    test_reset();
    test_fips();
`ifdef AES_KEY_STORE_EN
    test_store();
`endif
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
